mojo_cpu_top: RTL and testbench

Top level of an 8-bit, four-register, single-step teaching CPU for the Mojo FPGA board.
- Each press of a step button executes exactly one instruction from an internal program ROM.
- The trainer DIP switches are the input port; the 8 LEDs are the output port.
- All registers and both flags are exported for debug viewing.

---
 rtl/mojo_cpu_pkg.sv | 26 ++
 rtl/mojo_cpu_rom.sv | 18 +
 rtl/mojo_cpu_top.sv | 146 ++++++++++++++
 tb/tb_mojo_cpu_top.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mojo_cpu_pkg.sv
// Shared types and the default program image for the Mojo single-step CPU.
package mojo_cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3,
    OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
    OP_INC = 4'h8, OP_DEC = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
    OP_IN  = 4'hC, OP_OUT = 4'hD, OP_JMP = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {CC_ALWAYS = 2'b00, CC_Z = 2'b01, CC_C = 2'b10, CC_NZ = 2'b11} cond_e;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FETCH2, S_EXEC} state_e;

  // Words 00..0F of the demo program; everything above reads as 00.
  localparam int IMG_LEN = 16;
  localparam logic [IMG_LEN-1:0][7:0] ROM_IMAGE = {
    8'h00, 8'hF0, 8'hD0, 8'hA0, 8'hF0, 8'h0C, 8'hE8, 8'h94,
    8'hD0, 8'hC8, 8'h45, 8'h31, 8'h03, 8'h14, 8'h05, 8'h10
  };

  function automatic logic two_byte(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/mojo_cpu_rom.sv
// Combinational program ROM: address -> byte from the package image.
module mojo_cpu_rom
  import mojo_cpu_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] addr,
  output logic [7:0]    data
);

  logic [7:0] addr8;

  always_comb begin
    addr8 = 8'(addr);
    data  = (addr8[7:4] == 4'd0) ? ROM_IMAGE[addr8[3:0]] : 8'h00;
  end

endmodule

// File: rtl/mojo_cpu_top.sv
// 8-bit four-register single-step teaching CPU; one instruction per step press.
// Optional MOJO_CPU_FREERUN_EN: holding step high runs instructions back to back.
module mojo_cpu_top
  import mojo_cpu_pkg::*;
#(
  parameter int ROM_DEPTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [7:0] trainer_dip,
  output logic [7:0] led,
  output logic [7:0] r0view,
  output logic [7:0] r1view,
  output logic [7:0] r2view,
  output logic [7:0] r3view,
  output logic       zfview,
  output logic       cfview
);

  localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   step_s, go;
  state_e                 state, state_nxt;
  logic [AW-1:0]          pc;
  logic [7:0]             ir, imm, rom_data;
  logic [3:0][7:0]        regs;
  logic                   zf, cf, halted;

  mojo_cpu_rom #(.AW(AW)) u_rom (.addr(pc), .data(rom_data));

  assign step_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], step};

`ifdef MOJO_CPU_FREERUN_EN
  assign go = step_s;
`else
  logic step_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) step_d <= 1'b0;
    else      step_d <= step_s;
  assign go = step_s & ~step_d;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;

  // go outside IDLE is simply ignored, so bounces never queue work.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (go && !halted) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = two_byte(rom_data[7:4]) ? S_FETCH2 : S_EXEC;
      S_FETCH2: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  opcode_e    op;
  logic [1:0] rd, rs;
  logic [7:0] rd_val, rs_val;
  logic [8:0] alu_res;
  logic       wr_rd, upd_zf, upd_cf, led_wr, jmp_taken, set_halt;

  // Bit 8 of alu_res is the carry/borrow/shifted-out bit for every flag-setting op.
  always_comb begin
    op        = opcode_e'(ir[7:4]);
    rd        = ir[3:2];
    rs        = ir[1:0];
    rd_val    = regs[rd];
    rs_val    = regs[rs];
    alu_res   = 9'd0;
    wr_rd     = 1'b0;
    upd_zf    = 1'b0;
    upd_cf    = 1'b0;
    led_wr    = 1'b0;
    jmp_taken = 1'b0;
    set_halt  = 1'b0;
    case (op)
      OP_LDI: begin alu_res = {1'b0, imm};    wr_rd = 1'b1; end
      OP_MOV: begin alu_res = {1'b0, rs_val}; wr_rd = 1'b1; end
      OP_ADD: begin alu_res = {1'b0, rd_val} + {1'b0, rs_val}; wr_rd = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1; end
      OP_SUB: begin alu_res = {1'b0, rd_val} - {1'b0, rs_val}; wr_rd = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1; end
      OP_AND: begin alu_res = {1'b0, rd_val & rs_val}; wr_rd = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1; end
      OP_OR:  begin alu_res = {1'b0, rd_val | rs_val}; wr_rd = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1; end
      OP_XOR: begin alu_res = {1'b0, rd_val ^ rs_val}; wr_rd = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1; end
      OP_INC: begin alu_res = {1'b0, rd_val} + 9'd1; wr_rd = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1; end
      OP_DEC: begin alu_res = {1'b0, rd_val} - 9'd1; wr_rd = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1; end
      OP_SHL: begin alu_res = {rd_val, 1'b0}; wr_rd = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1; end
      OP_SHR: begin alu_res = {rd_val[0], 1'b0, rd_val[7:1]}; wr_rd = 1'b1; upd_zf = 1'b1; upd_cf = 1'b1; end
      OP_IN:  begin alu_res = {1'b0, trainer_dip}; wr_rd = 1'b1; upd_zf = 1'b1; end
      OP_OUT: led_wr = 1'b1;
      OP_JMP: case (cond_e'(rd))
                CC_ALWAYS: jmp_taken = 1'b1;
                CC_Z:      jmp_taken = zf;
                CC_C:      jmp_taken = cf;
                CC_NZ:     jmp_taken = ~zf;
                default:   jmp_taken = 1'b0;
              endcase
      OP_HLT: set_halt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= '0;
      ir     <= 8'h00;
      imm    <= 8'h00;
      regs   <= '0;
      led    <= 8'h00;
      zf     <= 1'b0;
      cf     <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  begin ir  <= rom_data; pc <= pc + AW'(1); end
        S_FETCH2: begin imm <= rom_data; pc <= pc + AW'(1); end
        S_EXEC: begin
          if (wr_rd)     regs[rd] <= alu_res[7:0];
          if (upd_zf)    zf <= (alu_res[7:0] == 8'h00);
          if (upd_cf)    cf <= alu_res[8];
          if (led_wr)    led <= rs_val;
          if (jmp_taken) pc <= imm[AW-1:0];
          if (set_halt)  halted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign r0view = regs[0];
  assign r1view = regs[1];
  assign r2view = regs[2];
  assign r3view = regs[3];
  assign zfview = zf;
  assign cfview = cf;

endmodule

// File: tb/tb_mojo_cpu_top.sv
// Directed bench for mojo_cpu_top: runs the default ROM program step by step.
module tb_mojo_cpu_top;

  logic       clk, rst, step;
  logic [7:0] trainer_dip, led, r0view, r1view, r2view, r3view;
  logic       zfview, cfview;

  int checks = 0;
  int errors = 0;

  mojo_cpu_top #(.ROM_DEPTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .step(step), .trainer_dip(trainer_dip), .led(led),
    .r0view(r0view), .r1view(r1view), .r2view(r2view), .r3view(r3view),
    .zfview(zfview), .cfview(cfview)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] dip;
    logic [7:0] r0, r1, r2, r3, led;
    logic       zf, cf;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [41:0] pack_exp(input vec_t v);
    return {v.r0, v.r1, v.r2, v.r3, v.led, v.zf, v.cf};
  endfunction

  function automatic logic [41:0] pack_act();
    return {r0view, r1view, r2view, r3view, led, zfview, cfview};
  endfunction

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got r0..r3,led,zf,cf=%h_%h_%h_%h_%h_%b%b want %h_%h_%h_%h_%h_%b%b",
               name, act[41:34], act[33:26], act[25:18], act[17:10], act[9:2], act[1], act[0],
               exp[41:34], exp[33:26], exp[25:18], exp[17:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic do_step();
    @(negedge clk) step = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    //            dip    r0     r1     r2     r3     led    zf    cf
    vecs[0]  = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0}; // LDI r0,05
    vecs[1]  = '{8'h00, 8'h05, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0}; // LDI r1,03
    vecs[2]  = '{8'h00, 8'h08, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0}; // ADD r0,r1
    vecs[3]  = '{8'hA5, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0}; // SUB r1,r1
    vecs[4]  = '{8'hA5, 8'h08, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0}; // IN r2
    vecs[5]  = '{8'hA5, 8'h08, 8'h00, 8'hA5, 8'h00, 8'h08, 1'b0, 1'b0}; // OUT r0
    vecs[6]  = '{8'hA5, 8'h08, 8'hFF, 8'hA5, 8'h00, 8'h08, 1'b0, 1'b1}; // DEC r1
    vecs[7]  = '{8'hA5, 8'h08, 8'hFF, 8'hA5, 8'h00, 8'h08, 1'b0, 1'b1}; // JMP C,0C
    vecs[8]  = '{8'hA5, 8'h10, 8'hFF, 8'hA5, 8'h00, 8'h08, 1'b0, 1'b0}; // SHL r0
    vecs[9]  = '{8'hA5, 8'h10, 8'hFF, 8'hA5, 8'h00, 8'h10, 1'b0, 1'b0}; // OUT r0
    vecs[10] = '{8'hA5, 8'h10, 8'hFF, 8'hA5, 8'h00, 8'h10, 1'b0, 1'b0}; // HLT
    vecs[11] = '{8'h3C, 8'h10, 8'hFF, 8'hA5, 8'h00, 8'h10, 1'b0, 1'b0}; // halted
    vecs[12] = '{8'h3C, 8'h10, 8'hFF, 8'hA5, 8'h00, 8'h10, 1'b0, 1'b0}; // halted

    rst = 1'b0;
    step = 1'b0;
    trainer_dip = 8'h00;
    for (int i = 0; i < 6; i++) @(negedge clk) step = ~step;
    step = 1'b0;
    check("reset_state", pack_act(), 42'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      trainer_dip = vecs[i].dip;
      do_step();
      check($sformatf("step%0d", i + 1), pack_act(), pack_exp(vecs[i]));
    end

    // Bounce: second edge lands while the first instruction is in flight.
    do_reset();
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    @(negedge clk) step = 1'b1;
    repeat (2) @(negedge clk);
    step = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_one_instr", pack_act(), {8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
    do_step();
    check("bounce_next_pc", pack_act(), {8'h05, 8'h03, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});

    // Reset arriving mid-instruction leaves nothing behind and restarts at pc 0.
    do_reset();
    do_step();
    do_step();
    @(negedge clk) step = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    step = 1'b0;
    @(negedge clk);
    check("mid_instr_reset", pack_act(), 42'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_reset_idle", pack_act(), 42'd0);
    do_step();
    check("mid_reset_restart", pack_act(), {8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
